// File: rtl/lcd_spi_pkg.sv
// Shared types, field layout and default panel init ROM for the LCD SPI scheduler.
// A ROM entry is {is_delay, dc, data[7:0]}; delay tokens carry a unit count in data.
package lcd_spi_pkg;

    localparam int DATA_W   = 8;
    localparam int ENTRY_W  = DATA_W + 2;
    localparam int INIT_MAX = 16;
    localparam int ROM_W    = INIT_MAX * ENTRY_W;
    localparam int PTR_W    = $clog2(INIT_MAX);

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_INIT     = 3'd2,
        ST_INIT_DLY = 3'd3,
        ST_IDLE     = 3'd4,
        ST_GNT0     = 3'd5,
        ST_GNT1     = 3'd6
    } lcd_state_e;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [ENTRY_W-1:0] cmd(input logic [DATA_W-1:0] d);
        return {1'b0, 1'b0, d};
    endfunction

    function automatic logic [ENTRY_W-1:0] dat(input logic [DATA_W-1:0] d);
        return {1'b0, 1'b1, d};
    endfunction

    function automatic logic [ENTRY_W-1:0] dly(input logic [DATA_W-1:0] units);
        return {1'b1, 1'b0, units};
    endfunction

    // Panel bring-up: soft reset, sleep-out, pixel format, orientation, TE, display-on.
    function automatic logic [ENTRY_W-1:0] rom_entry(input logic [PTR_W-1:0] idx);
        logic [ENTRY_W-1:0] e;
        case (idx)
            4'd0:    e = cmd(8'h01);
            4'd1:    e = dly(8'd3);
            4'd2:    e = cmd(8'h11);
            4'd3:    e = dly(8'd3);
            4'd4:    e = cmd(8'h3A);
            4'd5:    e = dat(8'h55);
            4'd6:    e = cmd(8'h36);
            4'd7:    e = dat(8'h00);
            4'd8:    e = cmd(8'h21);
            4'd9:    e = cmd(8'h13);
            4'd10:   e = cmd(8'h35);
            4'd11:   e = dat(8'h00);
            4'd12:   e = dly(8'd1);
            4'd13:   e = cmd(8'h29);
            4'd14:   e = dly(8'd2);
            4'd15:   e = cmd(8'h00);
            default: e = cmd(8'h00);
        endcase
        return e;
    endfunction

    function automatic logic [ROM_W-1:0] default_init_rom();
        logic [ROM_W-1:0] rom;
        rom = '0;
        for (int i = 0; i < INIT_MAX; i++) begin
            rom[i*ENTRY_W +: ENTRY_W] = rom_entry(PTR_W'(i));
        end
        return rom;
    endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin picker. The last completed owner loses the next tie;
// i_lock suppresses any pick while a packet or the init sequence owns the bus.
module lcd_rr_arb2
    import lcd_spi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_lock,
    input  logic       i_release,
    input  logic       i_release_id,
    output logic [1:0] o_pick
);

    logic r_last_grant;

    // Remember who finished last; reset favours requester 0 on the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (i_release) begin
            r_last_grant <= i_release_id;
        end
    end

    // Pick the single requester, or the one that did not finish last.
    always_comb begin
        o_pick = 2'b00;
        if (i_lock) begin
            o_pick = 2'b00;
        end else begin
            case (i_req)
                2'b01:   o_pick = 2'b01;
                2'b10:   o_pick = 2'b10;
                2'b11:   o_pick = r_last_grant ? 2'b01 : 2'b10;
                default: o_pick = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/lcd_spi_scheduler.sv
// Drives the panel reset pulse, streams the init ROM, then shares the SPI byte
// engine between two packet requesters one whole packet at a time.
module lcd_spi_scheduler
    import lcd_spi_pkg::*;
#(
    parameter int               RESET_HOLD_CYC = 50000,
    parameter int               RESET_WAIT_CYC = 250000,
    parameter int               DELAY_UNIT     = 50000,
    parameter int               INIT_LEN       = 16,
    parameter logic [ROM_W-1:0] INIT_ROM       = default_init_rom()
) (
    input  logic       clk,
    input  logic       rst,
    output logic       lcd_rst_n,
    output logic       init_done,
    input  logic       r0_valid,
    input  logic [7:0] r0_data,
    input  logic       r0_dc,
    input  logic       r0_last,
    output logic       r0_ready,
    input  logic       r1_valid,
    input  logic [7:0] r1_data,
    input  logic       r1_dc,
    input  logic       r1_last,
    output logic       r1_ready,
    output logic [1:0] grant,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    output logic       tx_last,
    input  logic       tx_ready
);

    localparam int CNT_MAX = imax(imax(RESET_HOLD_CYC, RESET_WAIT_CYC), 255 * DELAY_UNIT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RESET_WAIT_CYC - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(INIT_LEN - 1);

    lcd_state_e        r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [PTR_W-1:0]  r_ptr, w_ptr_next;
    logic              r_lcd_rst_n, r_init_done;
    logic              w_rst_release, w_init_finish;
    logic [ENTRY_W-1:0] w_entry;
    logic              w_is_dly, w_ent_dc;
    logic [DATA_W-1:0] w_ent_data;
    logic [CNT_W-1:0]  w_dly_total, w_dly_load;
    logic [1:0]        w_pick;
    logic              w_lock, w_release, w_release_id;

    assign w_entry                          = INIT_ROM[int'(r_ptr) * ENTRY_W +: ENTRY_W];
    assign {w_is_dly, w_ent_dc, w_ent_data} = w_entry;

    // The INIT cycle that fetches the token already counts as one idle cycle.
    assign w_dly_total = CNT_W'(int'(w_ent_data) * DELAY_UNIT);
    assign w_dly_load  = (w_dly_total < CNT_W'(2)) ? '0 : (w_dly_total - CNT_W'(2));

    assign w_lock       = (r_state != ST_IDLE);
    assign w_release_id = (r_state == ST_GNT1);
    assign w_release    = ((r_state == ST_GNT0) && r0_valid && r0_last && tx_ready) ||
                          ((r_state == ST_GNT1) && r1_valid && r1_last && tx_ready);

    assign lcd_rst_n = r_lcd_rst_n;
    assign init_done = r_init_done;

    lcd_rr_arb2 u_arb (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        ({r1_valid, r0_valid}),
        .i_lock       (w_lock),
        .i_release    (w_release),
        .i_release_id (w_release_id),
        .o_pick       (w_pick)
    );

    // State, counter, ROM pointer and the two sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RST_HOLD;
            r_cnt       <= HOLD_LOAD;
            r_ptr       <= '0;
            r_lcd_rst_n <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            if (w_rst_release) begin
                r_lcd_rst_n <= 1'b1;
            end
            if (w_init_finish) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // Next-state logic plus the transmitter/requester handshake routing.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_ptr_next    = r_ptr;
        w_rst_release = 1'b0;
        w_init_finish = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        tx_dc         = 1'b0;
        tx_last       = 1'b0;
        r0_ready      = 1'b0;
        r1_ready      = 1'b0;
        grant         = 2'b00;
        case (r_state)
            ST_RST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_next  = ST_RST_WAIT;
                    w_cnt_next    = WAIT_LOAD;
                    w_rst_release = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_RST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_INIT;
                    w_ptr_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_INIT: begin
                if (w_is_dly) begin
                    w_state_next = ST_INIT_DLY;
                    w_cnt_next   = w_dly_load;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = w_ent_data;
                    tx_dc    = w_ent_dc;
                    tx_last  = 1'b1;
                    if (!tx_ready) begin
                        w_state_next = ST_INIT;
                    end else if (r_ptr == LAST_PTR) begin
                        w_state_next  = ST_IDLE;
                        w_init_finish = 1'b1;
                    end else begin
                        w_ptr_next = r_ptr + PTR_W'(1);
                    end
                end
            end
            ST_INIT_DLY: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else if (r_ptr == LAST_PTR) begin
                    w_state_next  = ST_IDLE;
                    w_init_finish = 1'b1;
                end else begin
                    w_state_next = ST_INIT;
                    w_ptr_next   = r_ptr + PTR_W'(1);
                end
            end
            ST_IDLE: begin
                if (w_pick[0]) begin
                    w_state_next = ST_GNT0;
                end else if (w_pick[1]) begin
                    w_state_next = ST_GNT1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GNT0: begin
                grant    = 2'b01;
                tx_valid = r0_valid;
                tx_data  = r0_data;
                tx_dc    = r0_dc;
                tx_last  = r0_last;
                r0_ready = tx_ready;
                if (w_release) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_GNT0;
                end
            end
            ST_GNT1: begin
                grant    = 2'b10;
                tx_valid = r1_valid;
                tx_data  = r1_data;
                tx_dc    = r1_dc;
                tx_last  = r1_last;
                r1_ready = tx_ready;
                if (w_release) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_GNT1;
                end
            end
            default: begin
                w_state_next = ST_RST_HOLD;
                w_cnt_next   = HOLD_LOAD;
            end
        endcase
    end

endmodule
